// File: rtl/logic_unit_pkg.sv
// Shared op encoding and helpers for the pipelined logic unit.
// Ops 0..3 keep their legacy bit positions.
package logic_unit_pkg;

  localparam int OP_W    = 8;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_NOT  = 2;
  localparam int OP_XOR  = 3;
  localparam int OP_NAND = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_XNOR = 6;
  localparam int OP_ROTL = 7;

  function automatic logic is_onehot(
    input logic [OP_W-1:0] op
  );
    return (op != '0) &&
           ((op & (op - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational logic-op datapath: one-hot op decode and rotate.
// A non-one-hot op yields a zero result and raises err.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] res,
  output logic             err
);

  logic [SH_W-1:0]    amt;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   rot;

  // Amount wraps modulo WIDTH for non-power-of-two widths.
  assign amt = SH_W'(int'(b[SH_W-1:0]) % WIDTH);
  assign dbl = {ea, ea} << amt;
  assign rot = dbl[2*WIDTH-1:WIDTH];

  always_comb begin
    res = '0;
    err = !is_onehot(op);
    if (!err) begin
      unique case (1'b1)
        op[OP_AND]:  res = ea & b;
        op[OP_OR]:   res = ea | b;
        op[OP_NOT]:  res = ~ea;
        op[OP_XOR]:  res = ea ^ b;
        op[OP_NAND]: res = ~(ea & b);
        op[OP_NOR]:  res = ~(ea | b);
        op[OP_XNOR]: res = ~(ea ^ b);
        op[OP_ROTL]: res = rot;
      endcase
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with valid/ready handshake, result chaining
// and zero/parity/op_err status flags held with the result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             use_prev,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic             op_err
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             par_q, par_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] core_res;
  logic             core_err;
  logic             accept;

  assign ea = use_prev ? prev_q : a;

  logic_unit_core #(
    .WIDTH (WIDTH),
    .SH_W  (SH_W)
  ) u_core (
    .ea  (ea),
    .b   (b),
    .op  (op),
    .res (core_res),
    .err (core_err)
  );

  // Ready depends only on register state and out_ready.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    zero_d  = zero_q;
    par_d   = par_q;
    err_d   = err_q;
    prev_d  = prev_q;
    if (accept) begin
      valid_d = 1'b1;
      res_d   = core_res;
      zero_d  = (core_res == '0);
      par_d   = ^core_res;
      err_d   = core_err;
      prev_d  = core_res;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
      prev_q  <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      par_q   <= par_d;
      err_q   <= err_d;
      prev_q  <= prev_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign parity    = par_q;
  assign op_err    = err_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe at WIDTH=8.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] op;
  logic       use_prev;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero;
  logic       parity;
  logic       op_err;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .use_prev  (use_prev),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .parity    (parity),
    .op_err    (op_err)
  );

  typedef struct {
    logic [7:0] r;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [7:0] m_prev = 8'h00;
  logic or_cmd = 1'b1;
  logic rnd_bp = 1'b0;
  logic rnd_bit = 1'b1;

  assign out_ready = rnd_bp ? rnd_bit : or_cmd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  // Output monitor: pop one expectation per consumed result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks = checks + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL spurious_out: result=%h with empty scoreboard",
                 result);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (result !== e.r) begin
          errors = errors + 1;
          $display("FAIL result: got %h want %h", result, e.r);
        end
        checks = checks + 1;
        if (zero !== (e.r == 8'h00)) begin
          errors = errors + 1;
          $display("FAIL zero: got %b for %h", zero, e.r);
        end
        checks = checks + 1;
        if (parity !== ^e.r) begin
          errors = errors + 1;
          $display("FAIL parity: got %b for %h", parity, e.r);
        end
        checks = checks + 1;
        if (op_err !== e.e) begin
          errors = errors + 1;
          $display("FAIL op_err: got %b want %b", op_err, e.e);
        end
      end
    end
  end

  // Independent reference: rotate is done bit by bit.
  function automatic exp_t model(
    input logic [7:0] ea,
    input logic [7:0] bv,
    input logic [7:0] ov
  );
    exp_t m;
    logic [7:0] t;
    int n;
    m.r = 8'h00;
    m.e = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) if (ov[i]) n++;
    if (n == 1) begin
      m.e = 1'b0;
      case (ov)
        8'h01: m.r = ea & bv;
        8'h02: m.r = ea | bv;
        8'h04: m.r = ~ea;
        8'h08: m.r = ea ^ bv;
        8'h10: m.r = ~(ea & bv);
        8'h20: m.r = ~(ea | bv);
        8'h40: m.r = ~(ea ^ bv);
        default: begin
          t = ea;
          for (int k = 0; k < int'(bv[2:0]); k++)
            t = {t[6:0], t[7]};
          m.r = t;
        end
      endcase
    end
    return m;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(
    input logic [7:0] av,
    input logic [7:0] bv,
    input logic [7:0] ov,
    input logic       up,
    input logic [7:0] er,
    input logic       ee
  );
    bit ok;
    int n;
    exp_t e;
    in_valid = 1'b1;
    a = av;
    b = bv;
    op = ov;
    use_prev = up;
    ok = 0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        e.r = er;
        e.e = ee;
        q.push_back(e);
        m_prev = er;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL send_timeout: op=%h not accepted in %0d cycles",
               ov, n);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    use_prev = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    op = 8'h00;
    use_prev = 1'b0;
    or_cmd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks = checks + 1;
    if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b1 ||
        parity !== 1'b0 || op_err !== 1'b0 || in_ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL reset_state: ov=%b res=%h z=%b p=%b e=%b rdy=%b want 0 00 1 0 0 1",
               out_valid, result, zero, parity, op_err, in_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks = checks + 1;
      if (out_valid !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL reset_release: out_valid=%b want 0", out_valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_legacy();
    int c0;
    or_cmd = 1'b1;
    c0 = cyc;
    send(8'hC3, 8'h5A, 8'h01, 1'b0, 8'h42, 1'b0);
    send(8'hC3, 8'h5A, 8'h02, 1'b0, 8'hDB, 1'b0);
    send(8'hC3, 8'h5A, 8'h04, 1'b0, 8'h3C, 1'b0);
    send(8'hC3, 8'h5A, 8'h08, 1'b0, 8'h99, 1'b0);
    checks = checks + 1;
    if (cyc - c0 !== 4) begin
      errors = errors + 1;
      $display("FAIL throughput: 4 bundles took %0d cycles want 4",
               cyc - c0);
    end
    idle(2);
  endtask

  task automatic test_extended();
    send(8'h81, 8'h03, 8'h80, 1'b0, 8'h0C, 1'b0);
    send(8'hFF, 8'hFF, 8'h10, 1'b0, 8'h00, 1'b0);
    send(8'h5A, 8'h5A, 8'h40, 1'b0, 8'hFF, 1'b0);
    send(8'h0F, 8'hF0, 8'h20, 1'b0, 8'h00, 1'b0);
    send(8'h81, 8'h0B, 8'h80, 1'b0, 8'h0C, 1'b0);
    idle(2);
  endtask

  task automatic test_backpressure();
    or_cmd = 1'b0;
    send(8'h0F, 8'hF0, 8'h02, 1'b0, 8'hFF, 1'b0);
    in_valid = 1'b1;
    a = 8'h33;
    b = 8'h0C;
    op = 8'h08;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks = checks + 1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          result !== 8'hFF || op_err !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL hold: rdy=%b ov=%b res=%h err=%b want 0 1 ff 0",
                 in_ready, out_valid, result, op_err);
      end
    end
    @(posedge clk);
    #1;
    or_cmd = 1'b1;
    send(8'h33, 8'h0C, 8'h08, 1'b0, 8'h3F, 1'b0);
    checks = checks + 1;
    if (out_valid !== 1'b1 || result !== 8'h3F) begin
      errors = errors + 1;
      $display("FAIL swap: ov=%b res=%h want 1 3f", out_valid, result);
    end
    idle(2);
    checks = checks + 1;
    if (out_valid !== 1'b0 || result !== 8'h3F) begin
      errors = errors + 1;
      $display("FAIL consume: ov=%b res=%h want 0 3f", out_valid, result);
    end
  endtask

  task automatic test_chain();
    send(8'h0F, 8'h00, 8'h04, 1'b0, 8'hF0, 1'b0);
    send(8'h00, 8'h3C, 8'h08, 1'b1, 8'hCC, 1'b0);
    send(8'hAA, 8'h04, 8'h80, 1'b1, 8'hCC, 1'b0);
    idle(2);
  endtask

  task automatic test_illegal();
    send(8'hC3, 8'h5A, 8'h00, 1'b0, 8'h00, 1'b1);
    send(8'hC3, 8'h5A, 8'h03, 1'b0, 8'h00, 1'b1);
    send(8'hC3, 8'h5A, 8'h01, 1'b0, 8'h42, 1'b0);
    idle(2);
  endtask

  task automatic test_reset_mid();
    or_cmd = 1'b0;
    send(8'hFF, 8'hF3, 8'h01, 1'b0, 8'hF3, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_prev = 8'h00;
    checks = checks + 1;
    if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b1 ||
        parity !== 1'b0 || op_err !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL async_reset: ov=%b res=%h z=%b p=%b e=%b want 0 00 1 0 0",
               out_valid, result, zero, parity, op_err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    or_cmd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks = checks + 1;
      if (out_valid !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL discard: out_valid=%b want 0", out_valid);
      end
    end
    @(posedge clk);
    #1;
    send(8'h55, 8'h0F, 8'h02, 1'b1, 8'h0F, 1'b0);
    idle(2);
  endtask

  task automatic test_random();
    logic [7:0] av, bv, ov;
    logic up;
    exp_t m;
    rnd_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ov = 8'($urandom);
      else ov = 8'h01 << $urandom_range(0, 7);
      up = 1'($urandom_range(0, 1));
      m = model(up ? m_prev : av, bv, ov);
      send(av, bv, ov, up, m.r, m.e);
    end
    in_valid = 1'b0;
    rnd_bp = 1'b0;
    or_cmd = 1'b1;
    idle(3);
  endtask

  task automatic test_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d results never produced", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_extended();
    test_backpressure();
    test_chain();
    test_illegal();
    test_reset_mid();
    test_random();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the calculator's combinational 8-bit logic-operation block.
- Sits between the calculator-mode input capture (switches/keys) and the LED/7-segment result path.
- Adds configurable width, an extended one-hot op set with rotate, a valid/ready handshake with a one-entry output register, result chaining and status flags.

Parameters:
- WIDTH, 8: operand/result width in bits; legal values ≥ 2.
- OP_W, 8: one-hot opcode width; fixed at 8 in this generation, bits 0..7 defined below.
- SH_W, $clog2(WIDTH): number of b LSBs used as the rotate amount.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand/op bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; low SH_W bits give the rotate amount.
- op  input  OP_W  one-hot op select.
- use_prev  input  1  1 = replace a with last accepted result (chain mode).
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- parity  output  1  XOR-reduction of result.
- op_err  output  1  op was not exactly one-hot.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, result=0, zero=1, parity=0, op_err=0, prev_result=0.
- in_ready = !out_valid || out_ready, combinational; no combinational path from in_valid to in_ready.
- Accept occurs when in_valid && in_ready.
- Latency: result is visible on the edge of acceptance, so out_valid rises the cycle after accept.
- Back-to-back: with out_ready held at 1, one bundle is accepted every cycle (full throughput).
- Effective operand A: ea = use_prev ? prev_result : a.
- prev_result updates only on accept, not on consume.
- Op decode:
  - op[0] AND = ea&b
  - op[1] OR = ea|b
  - op[2] NOT = ~ea (b ignored)
  - op[3] XOR = ea^b
  - op[4] NAND
  - op[5] NOR
  - op[6] XNOR
  - op[7] ROTL = ea rotated left by b[SH_W-1:0] mod WIDTH; an amount ≥ WIDTH (non-power-of-two WIDTH) wraps modulo WIDTH.
- Ops 0..3 keep their legacy codes, so a 4-bit legacy op zero-extends to the same behaviour.
- Non-one-hot op (zero or multiple bits set): result=0, op_err=1; the bundle is still accepted and handshaked normally.
- op_err is registered with result and is 0 for any legal op.
- zero and parity are registered with result and derived from the stored value.
- Output hold: while out_valid && !out_ready, result/zero/parity/op_err stay stable and in_ready=0.
- Consume: out_valid && out_ready with no new accept gives out_valid=0 next cycle; result keeps its last value.
- Simultaneous consume and accept: out_valid stays 1 and the register loads the new result.
- Chain mode with use_prev=1 on the first bundle after reset: ea=0.
- Reset mid-transfer: any pending result is discarded; no output is produced for it after rst_n deasserts.
- All outputs are registers except in_ready.

Decomposition:
- Package logic_unit_pkg holds:
  - the op bit-index localparams OP_AND=0, OP_OR=1, OP_NOT=2, OP_XOR=3, OP_NAND=4, OP_NOR=5, OP_XNOR=6, OP_ROTL=7;
  - OP_W;
  - a function is_onehot(op).
- Sub-module logic_unit_core: purely combinational (ea, b, op) -> (res, err), parametrised on WIDTH.
- The top level adds the handshake register, prev_result and flag generation.

Test Plan:
- Reset: hold rst_n=0 → out_valid=0, result=0x00, zero=1, in_ready=1; release, no spurious out_valid.
- Legacy ops (WIDTH=8, out_ready=1): a=0xC3, b=0x5A, op=01/02/04/08 → results 0x42, 0xDB, 0x3C, 0x99, one per cycle, op_err=0, parity matches each value.
- Extended ops: a=0x81, b=0x03; ROTL (op=0x80) → 0x0C. NAND with a=b=0xFF → 0x00, zero=1. XNOR with a=b → 0xFF, parity=0.
- Backpressure: out_ready=0 after first accept of a=0x0F, b=0xF0, op=OR → result 0xFF held, in_ready=0, second bundle stalls. Raise out_ready → second bundle accepted the same cycle, no loss or duplication.
- Chain:
  - a=0x0F, op=NOT → 0xF0;
  - then use_prev=1, b=0x3C, XOR → 0xCC;
  - then use_prev=1, ROTL by b=0x04 → 0xCC.
- Illegal op: op=0x00 and op=0x03 → result=0x00, op_err=1, handshake completes. Assert rst_n=0 while out_valid=1 → outputs return to reset values immediately (asynchronous).
